// File: rtl/transformation_engine.sv
// transformation_engine: streams feature rows against loaded weight columns, one dot product per cycle.
// Optional macro TRANSFORM_SATURATE_EN: clamp products to DOT_PROD_WIDTH instead of wrapping.
module transformation_engine #(
    parameter int FEATURE_ROWS   = 6,
    parameter int FEATURE_COLS   = 96,
    parameter int WEIGHT_COLS    = 3,
    parameter int DATA_WIDTH     = 5,
    parameter int DOT_PROD_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     data_in [0:FEATURE_COLS-1],
    input  logic [$clog2(FEATURE_ROWS)-1:0] rd_row,
    output logic [DOT_PROD_WIDTH-1:0] fm_wm_row_out [0:WEIGHT_COLS-1],
    output logic                      busy,
    output logic                      done
);

    localparam int WCW   = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int FCW   = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int SUM_W = 2 * DATA_WIDTH + $clog2(FEATURE_COLS);
    localparam int EXT_W = (SUM_W > DOT_PROD_WIDTH) ? SUM_W : DOT_PROD_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_F,
        COMPUTE,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WCW-1:0]            r_w_cnt;
    logic [FCW-1:0]            r_f_cnt;
    logic [WCW-1:0]            r_c_cnt;
    logic [DATA_WIDTH-1:0]     r_weight [0:WEIGHT_COLS-1][0:FEATURE_COLS-1];
    logic [DATA_WIDTH-1:0]     r_feat   [0:FEATURE_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] r_prod   [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] r_rd     [0:WEIGHT_COLS-1];

    logic [SUM_W-1:0]          w_sum;
    logic [EXT_W-1:0]          w_sum_x;
    logic [DOT_PROD_WIDTH-1:0] w_prod;
    logic                      w_last_c;
    logic                      w_last_f;

    assign w_last_c      = (r_c_cnt == WCW'(WEIGHT_COLS - 1));
    assign w_last_f      = (r_f_cnt == FCW'(FEATURE_ROWS - 1));
    assign fm_wm_row_out = r_rd;

    // Full-precision dot product of the feature register with the selected weight column
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < FEATURE_COLS; k++) begin
            w_sum = w_sum + SUM_W'(r_feat[k]) * SUM_W'(r_weight[r_c_cnt][k]);
        end
        w_sum_x = EXT_W'(w_sum);
`ifdef TRANSFORM_SATURATE_EN
        if (w_sum_x > EXT_W'({DOT_PROD_WIDTH{1'b1}})) begin
            w_prod = {DOT_PROD_WIDTH{1'b1}};
        end else begin
            w_prod = w_sum_x[DOT_PROD_WIDTH-1:0];
        end
`else
        w_prod = w_sum_x[DOT_PROD_WIDTH-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/status outputs
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = LOAD_W;
            end
            LOAD_W: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && r_w_cnt == WCW'(WEIGHT_COLS - 1)) begin
                    w_next = WAIT_F;
                end
            end
            WAIT_F: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (w_last_c) w_next = w_last_f ? DONE : WAIT_F;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_next = LOAD_W;
            end
            default: w_next = IDLE;
        endcase
    end

    // Counters, weight scratch, feature register and product memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w_cnt  <= '0;
            r_f_cnt  <= '0;
            r_c_cnt  <= '0;
            r_weight <= '{default: '0};
            r_feat   <= '{default: '0};
            r_prod   <= '{default: '0};
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_w_cnt <= '0;
                        r_f_cnt <= '0;
                        r_c_cnt <= '0;
                    end
                end
                LOAD_W: begin
                    if (in_valid) begin
                        for (int k = 0; k < FEATURE_COLS; k++) begin
                            r_weight[r_w_cnt][k] <= data_in[k];
                        end
                        r_w_cnt <= r_w_cnt + WCW'(1);
                    end
                end
                WAIT_F: begin
                    if (in_valid) begin
                        r_feat  <= data_in;
                        r_c_cnt <= '0;
                    end
                end
                COMPUTE: begin
                    r_prod[r_f_cnt][r_c_cnt] <= w_prod;
                    r_c_cnt <= r_c_cnt + WCW'(1);
                    if (w_last_c && !w_last_f) begin
                        r_f_cnt <= r_f_cnt + FCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered read port; rows past the memory read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd <= '{default: '0};
        end else if (int'(rd_row) < FEATURE_ROWS) begin
            r_rd <= r_prod[rd_row];
        end else begin
            r_rd <= '{default: '0};
        end
    end

endmodule

// File: doc/transformation_engine.md
# transformation_engine

Parametrised GNN feature-transformation engine: computes the product matrix FM·WM, where FM is FEATURE_ROWS × FEATURE_COLS and WM is FEATURE_COLS × WEIGHT_COLS. Weight columns are loaded, then feature rows are streamed over a valid/ready handshake, and one dot product is computed per cycle. Each result is written into an internal product memory that downstream aggregation reads one row at a time. It sits between the feature/weight memory readers and the aggregation stage of the GNN layer.

## Interface
- FEATURE_ROWS, 6, number of feature rows (nodes) per run
- FEATURE_COLS, 96, feature vector length = weight column length
- WEIGHT_COLS, 3, number of weight columns (output features)
- DATA_WIDTH, 5, unsigned width of each feature and weight element
- DOT_PROD_WIDTH, 16, width of each stored product element
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a run from IDLE or DONE
- in_valid  in  1  data_in holds a weight column (LOAD_W) or feature row (WAIT_F)
- in_ready  out  1  engine accepts data_in this cycle
- data_in  in  FEATURE_COLS × DATA_WIDTH  unpacked vector [0:FEATURE_COLS-1]
- rd_row  in  $clog2(FEATURE_ROWS)  product-memory row to read
- fm_wm_row_out  out  WEIGHT_COLS × DOT_PROD_WIDTH  registered row rd_row
- busy  out  1  high in LOAD_W, WAIT_F, COMPUTE
- done  out  1  high while in DONE

## Operation
- States: IDLE, LOAD_W, WAIT_F, COMPUTE, DONE.
- IDLE/DONE: start → LOAD_W, clears w_cnt, f_cnt and c_cnt; the product memory is not cleared. start in any other state is ignored.
- LOAD_W: in_ready=1. Each handshake (in_valid & in_ready) writes data_in into weight scratch column w_cnt. After column WEIGHT_COLS-1 is accepted → WAIT_F.
- WAIT_F: in_ready=1. A handshake latches data_in into the feature register, sets c_cnt=0 → COMPUTE.
- COMPUTE: in_ready=0. Each cycle computes dot(feature, weight[c_cnt]) and writes it to product[f_cnt][c_cnt]. c_cnt increments each cycle.
  - After c_cnt = WEIGHT_COLS-1: if f_cnt = FEATURE_ROWS-1 → DONE, otherwise f_cnt++ → WAIT_F.
- Arithmetic: all operands are unsigned. The full-precision sum width is 2·DATA_WIDTH + $clog2(FEATURE_COLS); there is no intermediate truncation. The reduction to DOT_PROD_WIDTH is set by the configuration macro.
- Read port: fm_wm_row_out <= product[rd_row] every cycle, in any state.
  - Reading a row during the cycle it is being written returns the old value.
  - rd_row ≥ FEATURE_ROWS returns all zeros.
- Reset (asserted low at any time, including mid-run): state=IDLE; all counters, the scratch pad, the feature register and the product memory are set to 0. in_ready, busy, done and fm_wm_row_out are 0.

## Timing
- Read latency: 1 cycle from rd_row to fm_wm_row_out.
- start sampled at edge N → busy=1 and in_ready=1 from cycle N+1.
- Accepted weight column: written on the handshake edge. A back-to-back load takes WEIGHT_COLS cycles.
- Feature row accepted at edge M → products written at edges M+1 … M+WEIGHT_COLS. in_ready returns to 1 in cycle M+WEIGHT_COLS+1.
- Minimum run length with in_valid held high: 1 + WEIGHT_COLS + FEATURE_ROWS·(1+WEIGHT_COLS) cycles from start to done.
  - Defaults: 1 + 3 + 6·4 = 28 cycles.
- done rises the cycle after the last product write. It holds until the start that launches the next run, and clears on the cycle after that start.
- in_valid while in_ready=0 is ignored; the source must hold data_in until the handshake.

## Configuration
- TRANSFORM_SATURATE_EN defined: a sum > 2^DOT_PROD_WIDTH−1 is clamped to 2^DOT_PROD_WIDTH−1 (0xFFFF at defaults).
- Undefined: the low DOT_PROD_WIDTH bits are stored (wrap modulo 2^DOT_PROD_WIDTH).
- There is no other difference in behaviour or timing.

## Test plan
- Reset mid-COMPUTE (row 3, c_cnt=1) → next cycle state IDLE, busy=0, in_ready=0, and every fm_wm_row_out read returns 0.
- Weights = all 1 in column 0, all 2 in column 1, all 3 in column 2; feature row r = all (r+1); in_valid held high → done at cycle 28. Row r reads {96(r+1), 192(r+1), 288(r+1)}; row 5 reads {576, 1152, 1728}.
- All weights and features = 31 (sum 92256):
  - with TRANSFORM_SATURATE_EN, every element reads 65535;
  - without it, every element reads 26720.
- in_valid toggled randomly, including pulses while in_ready=0 during COMPUTE → same products as the back-to-back run, and no extra rows are consumed.
- start pulsed during WAIT_F → ignored (f_cnt unchanged). start in DONE → new run; products from the previous run stay readable until overwritten row by row.
- rd_row swept 0…7 each cycle → 1-cycle latency, and rows 6 and 7 return zeros.
